// File: rtl/kernel_loader.sv
// Double-buffered 5x5 coefficient store: byte-stream loads fill the shadow bank, frame_sync swaps it in.
// Row reads have 1-cycle latency; s_ready is high only in LOAD, and a full shadow bank stalls input until swapped.
module kernel_loader #(
  parameter int ROWS = 5,
  parameter int CW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 s_valid,
  input  logic [CW-1:0]        s_data,
  output logic                 s_ready,
  input  logic                 frame_sync,
  input  logic                 rd_en,
  input  logic [2:0]           addr,
  output logic [ROWS*CW-1:0]   data_out,
  output logic [12:0]          kernel_sum,
  output logic                 busy,
  output logic                 pending,
  output logic                 done,
  output logic                 err
);

  localparam int RW = ROWS * CW;
  localparam logic [2:0] LAST = 3'(ROWS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic [1:0]    state;
  logic          active_sel;
  logic [RW-1:0] bank0 [ROWS];
  logic [RW-1:0] bank1 [ROWS];
  logic [2:0]    col;
  logic [2:0]    row;
  logic [12:0]   acc;
  logic [RW-1:0] asm_q;
  logic          beat;
  logic [RW-1:0] asm_next;

  function automatic logic [RW-1:0] def_row(input int r);
    case (r)
      0, 4:    return RW'(40'h0103040301);
      1, 3:    return RW'(40'h030c130c03);
      default: return RW'(40'h0413201304);
    endcase
  endfunction

  assign beat     = s_valid & s_ready;
  assign asm_next = {asm_q[RW-CW-1:0], s_data};

  assign s_ready = (state == ST_LOAD);
  assign busy    = (state == ST_LOAD) || (state == ST_PEND);
  assign pending = (state == ST_PEND);
  assign done    = !rst && (state == ST_PEND) && frame_sync;
  assign err     = !rst && load_start && ((state == ST_LOAD) || (state == ST_PEND));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      active_sel <= 1'b0;
      col        <= '0;
      row        <= '0;
      acc        <= '0;
      asm_q      <= '0;
      kernel_sum <= 13'd200;
      data_out   <= '0;
      for (int r = 0; r < ROWS; r++) begin
        bank0[r] <= def_row(r);
        bank1[r] <= '0;
      end
    end else begin
      if (rd_en) begin
        if (addr <= LAST)
          data_out <= active_sel ? bank1[addr] : bank0[addr];
        else
          data_out <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (load_start) begin
            state <= ST_LOAD;
            col   <= '0;
            row   <= '0;
            acc   <= '0;
            asm_q <= '0;
          end
        end
        ST_LOAD: begin
          // A restart drops the partial kernel, including any byte offered this cycle.
          if (load_start) begin
            col   <= '0;
            row   <= '0;
            acc   <= '0;
            asm_q <= '0;
          end else if (beat) begin
            asm_q <= asm_next;
            acc   <= acc + 13'(s_data);
            if (col == LAST) begin
              if (active_sel)
                bank0[row] <= asm_next;
              else
                bank1[row] <= asm_next;
              col <= '0;
              if (row == LAST)
                state <= ST_PEND;
              else
                row <= row + 3'd1;
            end else begin
              col <= col + 3'd1;
            end
          end
        end
        ST_PEND: begin
          if (frame_sync) begin
            active_sel <= ~active_sel;
            kernel_sum <= acc;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
